dmem_ctrl: RTL and testbench

- Parametrised successor of the word-only data memory (DMem): word-organised RAM behind a one-outstanding request/response handshake.
- Adds RISC-V load/store sizes (byte, half, word; signed and unsigned loads), byte-lane write merging, configurable wait-state latency, and misalignment/range error reporting.
- Sits between the core's MEM stage and the data RAM.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 57 +++++
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory controller.
package dmem_pkg;

    localparam int unsigned BE_W  = 4;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic            write,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [BE_W-1:0] byte_en,
    output logic [31:0]     wdata_lanes,
    output logic [31:0]     load_ext,
    output logic            misaligned,
    output logic            illegal
);

    logic [31:0] shifted;

    always_comb begin
        byte_en     = '0;
        wdata_lanes = '0;
        load_ext    = '0;
        misaligned  = 1'b0;
        illegal     = 1'b0;
        // Addressed lane moved down to bit 0 for loads
        shifted     = rword >> {addr, 3'b000};

        case (funct3)
            F3_B, F3_BU: begin
                byte_en     = BE_W'(1) << addr;
                wdata_lanes = {4{wdata[7:0]}};
                load_ext    = (funct3 == F3_BU) ? {24'h0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                byte_en     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                load_ext    = (funct3 == F3_HU) ? {16'h0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
                misaligned  = addr[0];
            end
            F3_W: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                load_ext    = rword;
                misaligned  = |addr;
            end
            default: illegal = 1'b1;
        endcase

        // Unsigned variants exist only for loads
        if (write && funct3[2]) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-organised data RAM behind a one-outstanding request/response handshake
// with sized loads/stores, configurable wait states and error reporting.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    logic [31:0]       mem [DEPTH_WORDS];
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    resp_t             pend;

    logic [ADDR_W-3:0] word_idx_c;
    logic [IDX_W-1:0]  ram_idx_c;
    logic              in_range_c;
    logic              accept_c;
    logic              err_c;
    logic [31:0]       rword_c;
    resp_t             resp_c;

    logic [BE_W-1:0]   byte_en;
    logic [31:0]       wdata_lanes;
    logic [31:0]       load_ext;
    logic              misaligned;
    logic              illegal;

    // Address decode; no wrap-around, anything past the array is an error
    assign word_idx_c = req_addr[ADDR_W-1:2];
    assign ram_idx_c  = req_addr[IDX_W+1:2];
    assign in_range_c = (word_idx_c >> IDX_W) == '0;
    assign rword_c    = mem[ram_idx_c];
    assign accept_c   = req_valid && req_ready;
    assign err_c      = misaligned || illegal || !in_range_c;

    always_comb begin
        resp_c.err   = err_c;
        resp_c.rdata = (err_c || req_write) ? 32'h0 : load_ext;
    end

    dmem_lane_align u_align (
        .write       (req_write),
        .funct3      (req_funct3),
        .addr        (req_addr[1:0]),
        .wdata       (req_wdata),
        .rword       (rword_c),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .load_ext    (load_ext),
        .misaligned  (misaligned),
        .illegal     (illegal)
    );

    // Store commits at the accept edge; array contents survive reset
    always_ff @(posedge clk) begin
        if (accept_c && !rst && req_write && !err_c) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byte_en[b]) begin
                    mem[ram_idx_c][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        pend      <= resp_c;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= resp_c.rdata;
                            resp_err   <= resp_c.err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= pend.rdata;
                        resp_err   <= pend.err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: three controllers (LATENCY 1, 0, 4) against a byte-array model.
module tb_dmem_ctrl;

    localparam int DEPTH = 16;
    localparam int NI    = 3;

    typedef struct {
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        has_lit;
        bit [31:0] lit_rdata;
        bit        lit_err;
    } req_t;

    typedef struct {
        int        due;
        bit [31:0] rdata;
        bit        err;
        bit        has_lit;
        bit [31:0] lit_rdata;
        bit        lit_err;
    } exp_t;

    logic        clk;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [2:0]  req_funct3 [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        resp_valid [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit [7:0] mem_m [NI][DEPTH*4];
    exp_t expq [NI][$];
    req_t sq   [NI][$];
    req_t cur_req     [NI];
    int   busy_until  [NI];
    bit   accept_next [NI];
    int   accepts [NI];
    int   issued  [NI];
    int   resp_seen [NI];
    int   dropped [NI];

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]));

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]));

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: byte-addressed memory, sizes 1/2/4, natural alignment
    function automatic void model_apply(input int i, input bit wr, input bit [2:0] f3,
                                        input bit [31:0] a, input bit [31:0] wd,
                                        output bit [31:0] rd, output bit er);
        int n;
        bit legal;
        bit [31:0] v;
        case (f3[1:0])
            2'd0:    n = 1;
            2'd1:    n = 2;
            2'd2:    n = 4;
            default: n = 0;
        endcase
        legal = (n != 0) && (wr ? !f3[2] : !(f3[2] && n == 4));
        er = !legal || (a >= 32'(DEPTH * 4));
        if (legal && (a % n) != 0) er = 1'b1;
        rd = '0;
        if (!er) begin
            if (wr) begin
                for (int b = 0; b < n; b++) mem_m[i][a + b] = wd[8*b +: 8];
            end else begin
                v = '0;
                for (int b = 0; b < n; b++) v = v | (32'(mem_m[i][a + b]) << (8 * b));
                if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endfunction

    // Compare process: every cycle check handshake and responses against the model
    always @(negedge clk) begin
        bit        exp_rv;
        bit        exp_rdy;
        exp_t      e;
        bit [31:0] rd;
        bit        er;
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                dropped[i] += expq[i].size();
                expq[i].delete();
                busy_until[i]  = 0;
                accept_next[i] = 1'b0;
                chk($sformatf("reset_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
            end else begin
                exp_rv = (expq[i].size() > 0) && (expq[i][0].due == cyc);
                chk($sformatf("resp_valid[%0d]@%0d", i, cyc), 32'(resp_valid[i]), 32'(exp_rv));
                if (exp_rv) begin
                    e = expq[i].pop_front();
                    if (resp_valid[i]) begin
                        resp_seen[i]++;
                        chk($sformatf("rdata[%0d]@%0d", i, cyc), resp_rdata[i], e.rdata);
                        chk($sformatf("err[%0d]@%0d", i, cyc), 32'(resp_err[i]), 32'(e.err));
                        if (e.has_lit) begin
                            chk($sformatf("lit_rdata[%0d]@%0d", i, cyc), resp_rdata[i], e.lit_rdata);
                            chk($sformatf("lit_err[%0d]@%0d", i, cyc), 32'(resp_err[i]), 32'(e.lit_err));
                        end
                    end
                end
                exp_rdy = (cyc >= busy_until[i]);
                chk($sformatf("req_ready[%0d]@%0d", i, cyc), 32'(req_ready[i]), 32'(exp_rdy));
                accept_next[i] = req_valid[i] && exp_rdy;
                if (accept_next[i]) begin
                    model_apply(i, req_write[i], req_funct3[i], req_addr[i], req_wdata[i], rd, er);
                    e.due       = cyc + 1 + lat_of(i);
                    e.rdata     = rd;
                    e.err       = er;
                    e.has_lit   = cur_req[i].has_lit;
                    e.lit_rdata = cur_req[i].lit_rdata;
                    e.lit_err   = cur_req[i].lit_err;
                    expq[i].push_back(e);
                    busy_until[i] = cyc + lat_of(i) + 2;
                    accepts[i]++;
                end
            end
        end
    end

    task automatic add(input int i, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit hl, input bit [31:0] lr, input bit le);
        req_t r;
        r.wr = wr; r.f3 = f3; r.addr = a; r.wdata = wd;
        r.has_lit = hl; r.lit_rdata = lr; r.lit_err = le;
        sq[i].push_back(r);
    endtask

    task automatic add_random(input int i, input int count);
        bit [2:0] tbl [10];
        bit [2:0] f3;
        bit [31:0] a;
        int n;
        tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        for (int k = 0; k < count; k++) begin
            f3 = tbl[$urandom_range(0, 9)];
            a  = 32'($urandom_range(0, DEPTH * 4 + 7));
            n  = (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 1;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            add(i, 1'($urandom_range(0, 1)), f3, a, $urandom, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic send_one(input int i, input req_t r, input int gap);
        bit acc;
        int t;
        repeat (gap) begin
            req_valid[i] = 1'b0;
            @(posedge clk); #1;
        end
        cur_req[i]    = r;
        req_write[i]  = r.wr;
        req_funct3[i] = r.f3;
        req_addr[i]   = r.addr;
        req_wdata[i]  = r.wdata;
        req_valid[i]  = 1'b1;
        issued[i]++;
        t = 0;
        forever begin
            @(posedge clk);
            acc = accept_next[i];
            #1;
            if (acc) break;
            t++;
            if (t > 64) begin
                nchk++;
                nerr++;
                $display("FAIL accept_timeout[%0d]: request never accepted", i);
                break;
            end
        end
    endtask

    task automatic drain_queue(input int i, input int max_gap);
        req_t r;
        while (sq[i].size() > 0) begin
            r = sq[i].pop_front();
            send_one(i, r, $urandom_range(0, max_gap));
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic run_reset_test;
        req_t r;
        r.wr = 1'b1; r.f3 = 3'd2; r.addr = 32'hC; r.wdata = 32'h5A5A1234;
        r.has_lit = 1'b1; r.lit_rdata = 32'h0; r.lit_err = 1'b0;
        send_one(2, r, 1);
        r.wr = 1'b0; r.addr = 32'h0; r.has_lit = 1'b0;
        send_one(2, r, 0);
        req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst[2] = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready[2]), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        r.wr = 1'b0; r.f3 = 3'd2; r.addr = 32'hC;
        r.has_lit = 1'b1; r.lit_rdata = 32'h5A5A1234; r.lit_err = 1'b0;
        send_one(2, r, 0);
        req_valid[2] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_funct3[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
            busy_until[i] = 0; accept_next[i] = 1'b0;
            accepts[i] = 0; issued[i] = 0; resp_seen[i] = 0; dropped[i] = 0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", i), resp_rdata[i], 32'd0);
            chk($sformatf("rst_err[%0d]", i), 32'(resp_err[i]), 32'd0);
            chk($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
        end

        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++)
                add(i, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0, 32'h0, 1'b0);

        add(0, 1, 3'd2, 32'h0, 32'hAAAABBBB, 1, 32'h0, 0);
        add(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'hAAAABBBB, 0);
        add(0, 1, 3'd2, 32'h8, 32'h11223344, 1, 32'h0, 0);
        add(0, 1, 3'd0, 32'h9, 32'h000000FF, 1, 32'h0, 0);
        add(0, 1, 3'd1, 32'hA, 32'h0000BEEF, 1, 32'h0, 0);
        add(0, 0, 3'd2, 32'h8, 32'h0, 1, 32'hBEEFFF44, 0);
        add(0, 1, 3'd2, 32'h4, 32'h80F07F01, 1, 32'h0, 0);
        add(0, 0, 3'd0, 32'h7, 32'h0, 1, 32'hFFFFFF80, 0);
        add(0, 0, 3'd4, 32'h7, 32'h0, 1, 32'h00000080, 0);
        add(0, 0, 3'd1, 32'h6, 32'h0, 1, 32'hFFFF80F0, 0);
        add(0, 0, 3'd5, 32'h4, 32'h0, 1, 32'h00007F01, 0);
        add(0, 0, 3'd2, 32'h2, 32'h0, 1, 32'h0, 1);
        add(0, 1, 3'd1, 32'h5, 32'h00001234, 1, 32'h0, 1);
        add(0, 0, 3'd2, 32'h4, 32'h0, 1, 32'h80F07F01, 0);
        add(0, 0, 3'd2, 32'(DEPTH * 4), 32'h0, 1, 32'h0, 1);
        add(0, 0, 3'd3, 32'h0, 32'h0, 1, 32'h0, 1);
        add_random(0, 200);
        add_random(1, 40);
        add_random(2, 40);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        fork
            drain_queue(0, 2);
            drain_queue(1, 0);
            begin
                drain_queue(2, 0);
                run_reset_test();
            end
        join

        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("pending_left[%0d]", i), 32'(expq[i].size()), 32'd0);
            chk($sformatf("accepts_vs_issued[%0d]", i), 32'(accepts[i]), 32'(issued[i]));
            chk($sformatf("responses_vs_accepts[%0d]", i),
                32'(resp_seen[i] + dropped[i]), 32'(accepts[i]));
        end
        chk("dropped_by_reset", 32'(dropped[2]), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
